// File: rtl/swervolf_uart_pkg.sv
// Shared types and constants for the SweRVolf UART receiver.
package swervolf_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/swervolf_uart_rx_fifo.sv
// Receive FIFO: extra pointer MSB separates full from empty; head is shown combinationally.
module swervolf_uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/swervolf_uart_rx.sv
// 8N1 UART receiver with framing check and output FIFO.
// Define SWERVOLF_UART_RX_PARITY_EN for 8E1 framing with parity checking.
module swervolf_uart_rx
  import swervolf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_serial,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow,
  input  logic       i_clr_ovf,
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_e              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bad;
  logic                   r_frame_err;
  logic                   r_overflow;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   w_rx_s;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_par_bad   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= FULL_CNT;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == HALF_CNT) begin
            if (w_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_cnt     <= FULL_CNT;
              r_idx     <= '0;
              r_par_bad <= 1'b0;
              r_state   <= DATA;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_shift[r_idx] <= w_rx_s;
            r_cnt          <= FULL_CNT;
            if (r_idx == LAST_IDX) begin
`ifdef SWERVOLF_UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef SWERVOLF_UART_RX_PARITY_EN
        PARITY: begin
          if (r_cnt == '0) begin
            r_cnt   <= FULL_CNT;
            r_state <= STOP;
            if ((^r_shift) ^ w_rx_s) begin
              r_frame_err <= 1'b1;
              r_par_bad   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          // Sampling mid-stop leaves half a bit to catch an immediately following start bit.
          if (r_cnt == '0) begin
            if (w_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_push = (r_state == STOP) && (r_cnt == '0) && w_rx_s && !r_par_bad;
  assign w_pop  = o_valid && i_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  swervolf_uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_rdata (o_data)
  );

  assign o_valid     = !w_empty;
  assign o_frame_err = r_frame_err;
  assign o_overflow  = r_overflow;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_swervolf_uart_rx.sv
// Scoreboard bench for swervolf_uart_rx: directed frames, a monitor pops expected bytes.
module tb_swervolf_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef SWERVOLF_UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk;
  logic       rstn;
  logic       i_serial;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overflow;
  logic       i_clr_ovf;
  logic       o_busy;

  int         n_checks;
  int         n_errors;
  int         err_seen;
  bit         sb_en;
  logic [7:0] exp_q[$];

  swervolf_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_serial    (i_serial),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow),
    .i_clr_ovf   (i_clr_ovf),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted byte against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rstn && o_frame_err) err_seen++;
      if (rstn && sb_en && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", o_data);
        end else begin
          check("rx_byte", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic v);
    i_serial = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_v, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_BITS != 0) send_bit((^d) ^ par_flip);
    send_bit(stop_v);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
    #1;
    check({name, "_empty"}, {31'h0, o_valid}, 0);
  endtask

  initial begin
    int e0;
    int bc;
    n_checks  = 0;
    n_errors  = 0;
    err_seen  = 0;
    sb_en     = 1'b1;
    rstn      = 1'b0;
    i_serial  = 1'b1;
    i_ready   = 1'b0;
    i_clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {20'h0, o_data, o_valid, o_frame_err, o_overflow, o_busy}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("post_reset_idle", {20'h0, o_data, o_valid, o_frame_err, o_overflow, o_busy}, 0);
    @(negedge clk);

    // Back-to-back bytes with a ready consumer.
    i_ready = 1'b1;
    e0 = err_seen;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'hA3, 1'b1, 1'b0);
    wait_drain("b2b_drain");
    check("b2b_no_err", err_seen - e0, 0);

    // One-cycle glitch on an idle line.
    e0 = err_seen;
    bc = 0;
    i_serial = 1'b0;
    @(negedge clk);
    i_serial = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (o_busy) bc++;
    end
    check("glitch_busy_window", {31'h0, (bc >= 8 && bc <= 10)}, 1);
    check("glitch_no_err", err_seen - e0, 0);
    check("glitch_no_push", {31'h0, o_valid}, 0);
    @(negedge clk);

    // Bad stop bit followed by a long break, then a good byte.
    e0 = err_seen;
    send_byte(8'h41, 1'b0, 1'b0);
    i_serial = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    i_serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1, 1'b0);
    wait_drain("break_drain");
    check("break_one_err", err_seen - e0, 1);

    // Overflow: five bytes into a four-entry FIFO with no consumer.
    i_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= DEPTH) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1, 1'b0);
    end
    #1;
    check("ovf_set", {31'h0, o_overflow}, 1);
    check("ovf_valid", {31'h0, o_valid}, 1);
    @(negedge clk);
    i_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", {31'h0, o_overflow}, 1);
    @(negedge clk);
    i_clr_ovf = 1'b1;
    @(negedge clk);
    i_clr_ovf = 1'b0;
    #1;
    check("ovf_cleared", {31'h0, o_overflow}, 0);
    @(negedge clk);

    // Full FIFO with a pop exactly in the push cycle: push accepted, no overflow.
    i_ready = 1'b0;
    for (int b = 0; b < DEPTH; b++) begin
      exp_q.push_back(8'h11 + 8'(b));
      send_byte(8'h11 + 8'(b), 1'b1, 1'b0);
    end
    exp_q.push_back(8'h15);
    fork
      send_byte(8'h15, 1'b1, 1'b0);
      begin
        repeat (154 + 16 * PAR_BITS) @(posedge clk);
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
      end
    join
    #1;
    check("full_pop_push_no_ovf", {31'h0, o_overflow}, 0);
    check("full_pop_push_remaining", exp_q.size(), DEPTH);
    @(negedge clk);
    i_ready = 1'b1;
    wait_drain("full_pop_push_drain");

    // Reset in the middle of a frame, then a clean byte.
    sb_en = 1'b0;
    fork
      send_byte(8'h7E, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {20'h0, o_data, o_valid, o_frame_err, o_overflow, o_busy}, 0);
        repeat (3) @(negedge clk);
        #1;
        check("midframe_reset_hold",
              {20'h0, o_data, o_valid, o_frame_err, o_overflow, o_busy}, 0);
        @(negedge clk);
        rstn = 1'b1;
      end
    join
    i_serial = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    #1;
    check("after_reset_no_x",
          {31'h0, $isunknown({o_data, o_valid, o_frame_err, o_overflow, o_busy})}, 0);
    check("after_reset_idle", {30'h0, o_valid, o_busy}, 0);
    @(negedge clk);
    exp_q.delete();
    sb_en = 1'b1;
    e0 = err_seen;
    exp_q.push_back(8'h30);
    send_byte(8'h30, 1'b1, 1'b0);
    wait_drain("after_reset_drain");
    check("after_reset_no_err", err_seen - e0, 0);

`ifdef SWERVOLF_UART_RX_PARITY_EN
    // Wrong parity is rejected; correct parity is delivered.
    e0 = err_seen;
    send_byte(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("parity_bad_err", err_seen - e0, 1);
    #1;
    check("parity_bad_no_push", {31'h0, o_valid}, 0);
    @(negedge clk);
    e0 = err_seen;
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1, 1'b0);
    wait_drain("parity_good_drain");
    check("parity_good_no_err", err_seen - e0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
